// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit that owns the HI/LO registers.
// Ports: clk; reset (async, active-low); op[3:0] request code; a/b[31:0] operands;
// busy (registered, high while an operation runs); hi/lo[31:0] committed registers;
// rdata[31:0] combinational MFHI/MFLO read data.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic [63:0]   mul_s, mul_u, res;
  logic [31:0]   ua, ub, uq, ur, sq, sr, qu, ru;
  logic          start;
  assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign mul_u = {32'b0, a} * {32'b0, b};
  // Signed divide through magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign; 0x80000000 / -1 wraps to 0x80000000 with rem 0.
  assign ua = a[31] ? -a : a;
  assign ub = b[31] ? -b : b;
  assign uq = (ub == 32'd0) ? 32'd0 : ua / ub;
  assign ur = (ub == 32'd0) ? 32'd0 : ua % ub;
  assign sq = (a[31] ^ b[31]) ? -uq : uq;
  assign sr = a[31] ? -ur : ur;
  assign qu = (b == 32'd0) ? 32'd0 : a / b;
  assign ru = (b == 32'd0) ? 32'd0 : a % b;
  assign start = (op >= 4'd1) && (op <= 4'd4);
  // A zero divisor re-stages the current HI/LO so the commit leaves them unchanged.
  assign res = (op == 4'd1) ? mul_s :
               (op == 4'd2) ? mul_u :
               (b == 32'd0) ? {hi_q, lo_q} :
               (op == 4'd3) ? {sr, sq} : {ru, qu};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    if (state_q == IDLE) begin
      if (start) begin
        {hi_n_d, lo_n_d} = res;
        cnt_d   = (op <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        state_d = RUN;
      end else begin
        hi_d = (op == 4'd7) ? a : hi_q;
        lo_d = (op == 4'd8) ? a : lo_q;
      end
    end else begin
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
      if (cnt_q <= CW'(1)) begin
        hi_d    = hi_n_q;
        lo_d    = lo_n_q;
        state_d = IDLE;
      end
    end
    busy_d = (state_d == RUN);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end
  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (op == 4'd5) ? hi_q : (op == 4'd6) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu; stimulus queues expected commits, a monitor checks them.
module tb_mdu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo, rdata;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int cyc;} exp_t;
  exp_t sb[$];
  int pass = 0, total = 0;
  mdu dut (.clk(clk), .reset(reset), .op(op), .a(a), .b(b),
           .busy(busy), .hi(hi), .lo(lo), .rdata(rdata));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (busy && n < 40);
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int cyc);
    exp_t e;
    e.hi = eh; e.lo = el; e.cyc = cyc;
    sb.push_back(e);
    op = o; a = x; b = y;
    @(posedge clk);
    #2;
    op = 4'd0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
    wait_idle();
  endtask
  task automatic mt(input logic [3:0] o, input logic [31:0] x);
    op = o; a = x;
    @(posedge clk);
    #2;
    op = 4'd0;
  endtask
  // Monitor: each busy run ends in a commit; compare committed HI/LO and run length.
  initial begin
    int run_len = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run_len = 0;
        prev = 1'b0;
      end else if (busy) begin
        run_len++;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
        if (sb.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
          chk("busy_cycles", 32'(run_len), 32'(e.cyc));
        end
        run_len = 0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    op = 4'd5;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    op = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    run_op(4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    mt(4'd7, 32'h12345678);
    chk("mthi_hi", hi, 32'h12345678);
    mt(4'd8, 32'h9ABCDEF0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    run_op(4'd3, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10);
    run_op(4'd4, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10);
    op = 4'd5;
    #1;
    chk("mfhi_rdata", rdata, 32'h12345678);
    op = 4'd6;
    #1;
    chk("mflo_rdata", rdata, 32'h9ABCDEF0);
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd12; e.cyc = 5;
      sb.push_back(e);
    end
    op = 4'd1; a = 32'd3; b = 32'd4;
    @(posedge clk); #2;
    op = 4'd8; a = 32'hDEAD;
    @(posedge clk); #2;
    chk("mtlo_ignored", lo, 32'h9ABCDEF0);
    op = 4'd1; a = 32'd5; b = 32'd5;
    @(posedge clk); #2;
    op = 4'd6;
    #1;
    chk("mflo_during_busy", rdata, 32'h9ABCDEF0);
    op = 4'd5;
    #1;
    chk("mfhi_during_busy", rdata, 32'h12345678);
    op = 4'd0;
    wait_idle();
    op = 4'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #2;
    op = 4'd0;
    repeat (3) begin
      @(posedge clk); #2;
    end
    chk("busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    #3;
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_hi", hi, 32'd0);
    chk("post_abort_lo", lo, 32'd0);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
